ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter SETUP_CYCLES, default 50, clock-low plus data-low overlap before clock release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles allowed between consecutive device falling edges (15 ms).
REQ-004 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-005 SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port kbd_clk  input  1  PS/2 clock, already synchronized and low-pass filtered.
REQ-007 SHALL have port kbd_dat  input  1  PS/2 data line as read back from the pin.
REQ-008 SHALL have port tx_data  input  8  byte to send to the device.
REQ-009 SHALL have port tx_start  input  1  single-cycle request to send tx_data.
REQ-010 SHALL have port clk_drive_low  output  1  1 means pull PS2_CLK low; 0 means release (open-drain).
REQ-011 SHALL have port dat_drive_low  output  1  1 means pull PS2_DAT low; 0 means release.
REQ-012 SHALL have port busy  output  1  high from accepted tx_start until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a transfer ends, successfully or not.
REQ-014 SHALL have port tx_err  output  1  valid with done; 1 means NACK or timeout; held until next accepted tx_start.

Function
REQ-015 SHALL use states IDLE, INHIBIT, REQUEST, SEND, ACK, RELEASE_WAIT, FINISH.
REQ-016 IDLE: drives released and busy=0; tx_start=1 latches tx_data, computes odd parity (~^tx_data), clears tx_err, and moves to INHIBIT on the next edge.
REQ-017 INHIBIT: clk_drive_low=1 and dat_drive_low=0 for exactly INHIBIT_CYCLES cycles, then REQUEST.
REQ-018 REQUEST: clk_drive_low=1 and dat_drive_low=1 (start bit) for exactly SETUP_CYCLES cycles, then SEND with clk_drive_low=0.
REQ-019 Falling edge SHALL be detected as kbd_clk sampled 1 on the previous cycle and 0 on the current cycle, using one history register.
REQ-020 SEND: a 4-bit bit index starts at 0; on each falling edge, drive bit index k, with dat_drive_low = ~bit, then increment the index.
REQ-021 SEND bit order: k=0..7 are tx_data LSB first, k=8 is parity, k=9 is stop (dat_drive_low=0).
REQ-022 SEND exit: after the stop-bit falling edge, go to ACK.
REQ-023 ACK: on the next falling edge, sample kbd_dat; 0 means ACK, 1 means NACK (tx_err=1); then go to RELEASE_WAIT.
REQ-024 RELEASE_WAIT: wait until kbd_clk=1 and kbd_dat=1 on the same cycle, then FINISH.
REQ-025 FINISH: done=1 for one cycle, then IDLE.
REQ-026 Timeout: a 20-bit counter clears on every falling edge and on entry to SEND; in SEND, ACK or RELEASE_WAIT, reaching TIMEOUT_CYCLES sets tx_err=1 and goes to FINISH.
REQ-027 Timeout release: drives SHALL be released in the cycle after the timeout is detected.
REQ-028 tx_start while busy=1 SHALL be ignored; tx_data changes while busy SHALL NOT affect the transfer.
REQ-029 tx_start in the same cycle as done SHALL be ignored; a new request is accepted only in IDLE.
REQ-030 clk_drive_low and dat_drive_low SHALL be registered outputs.
REQ-031 clk_drive_low SHALL be 1 only in INHIBIT and REQUEST.
REQ-032 dat_drive_low SHALL be 1 only in REQUEST and SEND.

Reset
REQ-033 resetN=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, clk_drive_low=0, dat_drive_low=0, busy=0, done=0, tx_err=0, and clear all counters and registers.
REQ-034 Reset mid-transfer SHALL abandon the byte with no done pulse; after resetN rises, the block is idle and accepts tx_start.

Verification
REQ-035 INHIBIT_CYCLES=20, SETUP_CYCLES=4: tx_start with tx_data=0xED -> clk_drive_low high 24 cycles, dat_drive_low high for the last 4, then device model clocks; bits seen 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK=0 -> done pulse, tx_err=0.
REQ-036 tx_data=0xF4 -> parity bit 0; device model NACKs (kbd_dat=1 at ACK edge) -> done pulse, tx_err=1.
REQ-037 tx_data=0xFF with TIMEOUT_CYCLES=100 -> device stops clocking after bit 3 -> done 100 cycles after the last falling edge, tx_err=1, both drives 0.
REQ-038 Second tx_start (0x00) during a transfer of 0xED -> ignored; bits seen are still 0xED; exactly one done pulse.
REQ-039 resetN asserted during SEND bit 5 -> drives 0 within the same cycle, busy=0, no done; next tx_start 0xAA completes normally with parity 1.
REQ-040 RELEASE_WAIT with kbd_dat held low 10 cycles after the ACK edge -> done pulse one cycle after kbd_dat returns high.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Host-side request/status bundle for the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       tx_err;

    modport master (
        output tx_data,
        output tx_start,
        input  busy,
        input  done,
        input  tx_err
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output busy,
        output done,
        output tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte sender: inhibit, request-to-send, 11-bit frame clocked by the device, ACK check.
// Transfer time is set by the device clock; tx_start is only accepted when idle, never queued.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          kbd_clk,
    input  logic          kbd_dat,
    output logic          clk_drive_low,
    output logic          dat_drive_low,
    ps2_host_tx_if.slave  host
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SEND,
        ACK,
        RELEASE_WAIT,
        FINISH
    } state_t;

    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] SET_LAST = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  data_q;
    logic        parity_q;
    logic [3:0]  bit_idx;
    logic [19:0] cnt;
    logic        kbd_clk_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        fall;
    logic        tx_bit;
    logic        timed_out;

    assign fall      = kbd_clk_q & ~kbd_clk;
    assign timed_out = (cnt == TO_LAST);

    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.tx_err = err_q;

    // Index 9 (stop) and anything beyond resolve to 1, i.e. data released.
    always_comb begin
        tx_bit = 1'b1;
        if (bit_idx < 4'd8)
            tx_bit = data_q[bit_idx[2:0]];
        else if (bit_idx == 4'd8)
            tx_bit = parity_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            data_q        <= '0;
            parity_q      <= 1'b0;
            bit_idx       <= '0;
            cnt           <= '0;
            kbd_clk_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            clk_drive_low <= 1'b0;
            dat_drive_low <= 1'b0;
        end else begin
            kbd_clk_q <= kbd_clk;
            done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.tx_start) begin
                        data_q        <= host.tx_data;
                        parity_q      <= ~^host.tx_data;
                        err_q         <= 1'b0;
                        busy_q        <= 1'b1;
                        clk_drive_low <= 1'b1;
                        cnt           <= '0;
                        state         <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt           <= '0;
                        dat_drive_low <= 1'b1;
                        state         <= REQUEST;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                REQUEST: begin
                    if (cnt == SET_LAST) begin
                        cnt           <= '0;
                        bit_idx       <= '0;
                        clk_drive_low <= 1'b0;
                        state         <= SEND;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                SEND: begin
                    if (fall) begin
                        cnt           <= '0;
                        bit_idx       <= bit_idx + 4'd1;
                        dat_drive_low <= ~tx_bit;
                        if (bit_idx == 4'd9)
                            state <= ACK;
                    end else if (timed_out) begin
                        err_q         <= 1'b1;
                        done_q        <= 1'b1;
                        dat_drive_low <= 1'b0;
                        clk_drive_low <= 1'b0;
                        state         <= FINISH;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                ACK: begin
                    if (fall) begin
                        cnt   <= '0;
                        err_q <= kbd_dat;
                        state <= RELEASE_WAIT;
                    end else if (timed_out) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                RELEASE_WAIT: begin
                    // Device must let go of both lines before the bus counts as idle again.
                    if (kbd_clk && kbd_dat) begin
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end else if (timed_out) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    busy_q        <= 1'b0;
                    clk_drive_low <= 1'b0;
                    dat_drive_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of byte transfers plus timeout and reset sequences.
module tb_ps2_host_tx;

    logic clk = 1'b0;
    logic resetN;
    logic kbd_clk;
    logic kbd_dat;
    logic clk_drive_low;
    logic dat_drive_low;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .SETUP_CYCLES  (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .kbd_clk      (kbd_clk),
        .kbd_dat      (kbd_dat),
        .clk_drive_low(clk_drive_low),
        .dat_drive_low(dat_drive_low),
        .host         (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       par;
        logic       err;
        logic       inject;
        int         hold;
    } vec_t;

    vec_t vt [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_xfer(input logic [7:0] d, output int cc, output int dd);
        int g;
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
        check("busy_at_start", 32'(bus.busy), 32'd1);
        check("err_cleared", 32'(bus.tx_err), 32'd0);
        cc = 0;
        dd = 0;
        g  = 0;
        while (clk_drive_low === 1'b1 && g < 1000) begin
            cc++;
            if (dat_drive_low === 1'b1) dd++;
            g++;
            tick();
        end
    endtask

    task automatic dev_clock(output logic b);
        kbd_clk = 1'b0;
        repeat (3) tick();
        kbd_clk = 1'b1;
        b = ~dat_drive_low;
        repeat (3) tick();
    endtask

    task automatic run_xfer(input vec_t v);
        int cc, dd, dc0;
        logic [9:0] seen;
        logic b, early_done;
        dc0 = done_cnt;
        start_xfer(v.data, cc, dd);
        check("inhibit_len", 32'(cc), 32'd24);
        check("setup_len", 32'(dd), 32'd4);
        check("start_bit", 32'(dat_drive_low), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (v.inject && k == 5) begin
                bus.tx_data  = 8'h00;
                bus.tx_start = 1'b1;
                tick();
                bus.tx_start = 1'b0;
            end
            dev_clock(b);
            seen[k] = b;
        end
        check("data_bits", 32'(seen[7:0]), 32'(v.data));
        check("parity_bit", 32'(seen[8]), 32'(v.par));
        check("stop_bit", 32'(seen[9]), 32'd1);
        kbd_dat = v.ack;
        tick();
        kbd_clk = 1'b0;
        tick();
        kbd_clk = 1'b1;
        early_done = 1'b0;
        if (v.ack == 1'b0) begin
            for (int i = 0; i < v.hold; i++) begin
                if (bus.done === 1'b1) early_done = 1'b1;
                tick();
            end
        end
        check("done_early", 32'(early_done), 32'd0);
        kbd_dat = 1'b1;
        tick();
        check("done_pulse", 32'(bus.done), 32'd1);
        check("tx_err", 32'(bus.tx_err), 32'(v.err));
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_end", 32'(bus.busy), 32'd0);
        check("drives_end", 32'({clk_drive_low, dat_drive_low}), 32'd0);
        repeat (5) tick();
        check("done_count", 32'(done_cnt - dc0), 32'd1);
        check("err_held", 32'(bus.tx_err), 32'(v.err));
    endtask

    initial begin
        int cc, dd, n, dc0;
        logic b;

        vt[0] = '{data: 8'hED, ack: 1'b0, par: 1'b1, err: 1'b0, inject: 1'b0, hold: 3};
        vt[1] = '{data: 8'hF4, ack: 1'b1, par: 1'b0, err: 1'b1, inject: 1'b0, hold: 0};
        vt[2] = '{data: 8'hED, ack: 1'b0, par: 1'b1, err: 1'b0, inject: 1'b1, hold: 3};
        vt[3] = '{data: 8'hED, ack: 1'b0, par: 1'b1, err: 1'b0, inject: 1'b0, hold: 10};
        vt[4] = '{data: 8'h00, ack: 1'b0, par: 1'b1, err: 1'b0, inject: 1'b0, hold: 3};

        resetN       = 1'b1;
        kbd_clk      = 1'b1;
        kbd_dat      = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        #1 resetN = 1'b0;
        #1;
        check("rst_drives", 32'({clk_drive_low, dat_drive_low}), 32'd0);
        check("rst_status", 32'({bus.busy, bus.done, bus.tx_err}), 32'd0);
        repeat (3) tick();
        resetN = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) run_xfer(vt[i]);

        // Device stops clocking after bit 3: expect timeout exactly 100 cycles after that edge.
        start_xfer(8'hFF, cc, dd);
        for (int k = 0; k < 3; k++) dev_clock(b);
        kbd_clk = 1'b0;
        tick();
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (n == 3) kbd_clk = 1'b1;
        end
        check("timeout_cycles", 32'(n), 32'd100);
        check("timeout_err", 32'(bus.tx_err), 32'd1);
        check("timeout_drives", 32'({clk_drive_low, dat_drive_low}), 32'd0);
        repeat (3) tick();

        // Reset during bit 5 of a transfer: immediate release, no done pulse.
        dc0 = done_cnt;
        start_xfer(8'hED, cc, dd);
        for (int k = 0; k < 5; k++) dev_clock(b);
        kbd_clk = 1'b0;
        tick();
        #2 resetN = 1'b0;
        #1;
        check("midrst_drives", 32'({clk_drive_low, dat_drive_low}), 32'd0);
        check("midrst_status", 32'({bus.busy, bus.done, bus.tx_err}), 32'd0);
        kbd_clk = 1'b1;
        repeat (2) tick();
        resetN = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
        run_xfer('{data: 8'hAA, ack: 1'b0, par: 1'b1, err: 1'b0, inject: 1'b0, hold: 3});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
